// File: rtl/pe_feeder.sv
`default_nettype none
// ============================================================================
// Module : pe_feeder
// Desc   : Full-search sequencer feeding the ME PE matrix from CPR/SPR memories
// Rev    : 1.0  initial release
// ============================================================================
module pe_feeder #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       cur_rd_en,
  output logic [$clog2(MACRO_DIM)-1:0]               cur_row,
  input  logic [8*MACRO_DIM-1:0]                     cur_data,
  output logic                                       srch_rd_en,
  output logic [$clog2(SEARCH_DIM)-1:0]              srch_row,
  output logic [$clog2(SEARCH_DIM)-1:0]              srch_col,
  input  logic [8*MACRO_DIM-1:0]                     srch_data,
  output logic [0:MACRO_DIM-1][7:0]                  pixel_cpr_out,
  output logic [0:MACRO_DIM-1][7:0]                  pixel_spr_out,
  output logic                                       en_cpr,
  output logic                                       en_spr,
  output logic                                       sel,
  input  logic                                       ad_ready,
  output logic                                       ad_valid,
  output logic [$clog2(SEARCH_DIM-MACRO_DIM+1)-1:0]  cand_x,
  output logic [$clog2(SEARCH_DIM-MACRO_DIM+1)-1:0]  cand_y
);
  localparam int c_ncand = SEARCH_DIM - MACRO_DIM + 1;
  localparam int c_mw    = $clog2(MACRO_DIM);
  localparam int c_sw    = $clog2(SEARCH_DIM);
  localparam int c_cw    = $clog2(c_ncand);
  localparam int c_dw    = 8 * MACRO_DIM;

  localparam logic [c_mw-1:0] c_cur_last = c_mw'(MACRO_DIM - 1);
  localparam logic [c_sw-1:0] c_row_last = c_sw'(SEARCH_DIM - 1);
  localparam logic [c_sw-1:0] c_col_last = c_sw'(c_ncand - 1);
  localparam logic [c_sw-1:0] c_fill     = c_sw'(MACRO_DIM - 1);
  localparam logic [c_cw-1:0] c_x_last   = c_cw'(c_ncand - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_CPR = 3'd1,
    SCAN     = 3'd2,
    DRAIN    = 3'd3,
    FIN      = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;

  logic [c_mw-1:0] r_cur_cnt, r_cur_row;
  logic            r_cur_all, r_cpr_vld;
  logic [c_dw-1:0] r_cpr_hold, w_cpr_row;

  logic [c_sw-1:0] r_rd_r, r_rd_x, r_srch_row, r_srch_col;
  logic            r_srch_pend;

  logic [c_dw-1:0] r_fifo0, r_fifo1, r_spr_hold, w_head, w_spr_row;
  logic            r_wr_ptr, r_rd_ptr;
  logic [1:0]      r_occ;
  logic [2:0]      w_load;
  logic            w_pop, w_last_rd;

  logic [c_sw-1:0] r_pop_k;
  logic [c_cw-1:0] r_pop_x, r_cand_x, r_cand_y;
  logic            r_pop_all, r_ad_valid;

  assign w_head    = r_rd_ptr ? r_fifo1 : r_fifo0;
  assign w_pop     = (r_occ != 2'd0) && ad_ready;
  assign w_load    = 3'(r_occ) + 3'(r_srch_pend);
  assign w_last_rd = (r_rd_x == c_col_last) && (r_rd_r == c_row_last);

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    sel         = 1'b0;
    cur_rd_en   = 1'b0;
    srch_rd_en  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = LOAD_CPR;
      end
      LOAD_CPR: begin
        busy      = 1'b1;
        cur_rd_en = !r_cur_all;
        if (r_cur_all && r_cpr_vld) w_state_nxt = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        sel  = 1'b1;
        // A same-cycle pop frees a slot, keeping one read per cycle sustainable
        srch_rd_en = (w_load < 3'd2) || w_pop;
        if (srch_rd_en && w_last_rd) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        sel  = 1'b1;
        if (r_pop_all) w_state_nxt = FIN;
      end
      FIN: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_cnt   <= '0;
      r_cur_row   <= '0;
      r_cur_all   <= 1'b0;
      r_cpr_vld   <= 1'b0;
      r_cpr_hold  <= '0;
      r_rd_r      <= '0;
      r_rd_x      <= '0;
      r_srch_row  <= '0;
      r_srch_col  <= '0;
      r_srch_pend <= 1'b0;
      r_fifo0     <= '0;
      r_fifo1     <= '0;
      r_spr_hold  <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_occ       <= 2'd0;
      r_pop_k     <= '0;
      r_pop_x     <= '0;
      r_pop_all   <= 1'b0;
      r_ad_valid  <= 1'b0;
      r_cand_x    <= '0;
      r_cand_y    <= '0;
    end else begin
      if (cur_rd_en) begin
        r_cur_row <= r_cur_cnt;
        r_cur_cnt <= (r_cur_cnt == c_cur_last) ? '0 : r_cur_cnt + 1'b1;
      end
      if (cur_rd_en && (r_cur_cnt == c_cur_last)) r_cur_all <= 1'b1;
      else if (r_state != LOAD_CPR)               r_cur_all <= 1'b0;
      r_cpr_vld <= cur_rd_en;
      if (r_cpr_vld) r_cpr_hold <= cur_data;

      if (srch_rd_en) begin
        r_srch_row <= r_rd_r;
        r_srch_col <= r_rd_x;
        if (r_rd_r == c_row_last) begin
          r_rd_r <= '0;
          r_rd_x <= (r_rd_x == c_col_last) ? '0 : r_rd_x + 1'b1;
        end else begin
          r_rd_r <= r_rd_r + 1'b1;
        end
      end
      r_srch_pend <= srch_rd_en;

      if (r_srch_pend) begin
        if (r_wr_ptr) r_fifo1 <= srch_data;
        else          r_fifo0 <= srch_data;
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr   <= ~r_rd_ptr;
        r_spr_hold <= w_head;
      end
      case ({r_srch_pend, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase

      // Pop-side column tracking: pulse k of a column is r_pop_k+1
      r_ad_valid <= 1'b0;
      if (w_pop) begin
        if (r_pop_k >= c_fill) begin
          r_ad_valid <= 1'b1;
          r_cand_x   <= r_pop_x;
          r_cand_y   <= c_cw'(r_pop_k - c_fill);
        end
        if (r_pop_k == c_row_last) begin
          r_pop_k <= '0;
          if (r_pop_x == c_x_last) begin
            r_pop_x   <= '0;
            r_pop_all <= 1'b1;
          end else begin
            r_pop_x <= r_pop_x + 1'b1;
          end
        end else begin
          r_pop_k <= r_pop_k + 1'b1;
        end
      end
      if (r_state == FIN) r_pop_all <= 1'b0;
    end
  end

  assign cur_row   = cur_rd_en  ? r_cur_cnt : r_cur_row;
  assign srch_row  = srch_rd_en ? r_rd_r    : r_srch_row;
  assign srch_col  = srch_rd_en ? r_rd_x    : r_srch_col;
  assign en_cpr    = r_cpr_vld;
  assign en_spr    = w_pop;
  assign w_cpr_row = r_cpr_vld ? cur_data : r_cpr_hold;
  assign w_spr_row = w_pop     ? w_head   : r_spr_hold;
  assign ad_valid  = r_ad_valid;
  assign cand_x    = r_cand_x;
  assign cand_y    = r_cand_y;

  for (genvar i = 0; i < MACRO_DIM; i++) begin : g_col
    assign pixel_cpr_out[i] = w_cpr_row[8*i +: 8];
    assign pixel_spr_out[i] = w_spr_row[8*i +: 8];
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_feeder.sv
`default_nettype none
// ============================================================================
// Module : tb_pe_feeder
// Desc   : Scoreboard bench for pe_feeder (default and 4x8 configurations)
// Rev    : 1.0  initial release
// ============================================================================
module tb_pe_feeder;
  typedef logic [0:15][7:0] pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, ad_ready;
  logic busy, done, cur_rd_en, srch_rd_en, en_cpr, en_spr, sel, ad_valid;
  logic [3:0]   cur_row;
  logic [5:0]   srch_row, srch_col, cand_x, cand_y;
  logic [127:0] cur_data, srch_data;
  pix_t         pixel_cpr_out, pixel_spr_out;

  logic start_s, busy_s, done_s, cur_rd_en_s, srch_rd_en_s, en_cpr_s, en_spr_s, sel_s, ad_valid_s;
  logic [1:0]       cur_row_s;
  logic [2:0]       srch_row_s, srch_col_s, cx_s, cy_s;
  logic [31:0]      cur_data_s, srch_data_s;
  logic [0:3][7:0]  pix_cpr_s, pix_spr_s;

  pe_feeder u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .cur_rd_en(cur_rd_en), .cur_row(cur_row), .cur_data(cur_data),
    .srch_rd_en(srch_rd_en), .srch_row(srch_row), .srch_col(srch_col), .srch_data(srch_data),
    .pixel_cpr_out(pixel_cpr_out), .pixel_spr_out(pixel_spr_out),
    .en_cpr(en_cpr), .en_spr(en_spr), .sel(sel), .ad_ready(ad_ready),
    .ad_valid(ad_valid), .cand_x(cand_x), .cand_y(cand_y)
  );

  pe_feeder #(.MACRO_DIM(4), .SEARCH_DIM(8)) u_small (
    .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s),
    .cur_rd_en(cur_rd_en_s), .cur_row(cur_row_s), .cur_data(cur_data_s),
    .srch_rd_en(srch_rd_en_s), .srch_row(srch_row_s), .srch_col(srch_col_s), .srch_data(srch_data_s),
    .pixel_cpr_out(pix_cpr_s), .pixel_spr_out(pix_spr_s),
    .en_cpr(en_cpr_s), .en_spr(en_spr_s), .sel(sel_s), .ad_ready(1'b1),
    .ad_valid(ad_valid_s), .cand_x(cx_s), .cand_y(cy_s)
  );

  // Memory models: pixel(row, col) = (row*7 + col) & 8'hFF, registered read
  function automatic logic [127:0] row_pix(input int r, input int c0);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = 8'((r * 7 + c0 + i) & 255);
    return v;
  endfunction

  always @(posedge clk) begin
    if (cur_rd_en)    cur_data    <= row_pix(int'(cur_row), 0);
    if (srch_rd_en)   srch_data   <= row_pix(int'(srch_row), int'(srch_col));
    if (cur_rd_en_s)  cur_data_s  <= {4{8'h5A}};
    if (srch_rd_en_s) srch_data_s <= {4{8'h5A}};
  end

  int n_vec = 0, n_err = 0, cyc = 0, t_start = 0, t_last_ad = 0;
  int n_cpr, n_spr, n_ad, out_cnt, n_cpr_s = 0, n_spr_s = 0, n_ad_s = 0;
  bit done_seen, hit, done_s_seen = 0;
  pix_t             q_cpr[$], q_spr[$];
  logic [11:0]      q_cand[$];
  logic [5:0]       q_s[$];

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_expect();
    pix_t e;
    q_cpr.delete(); q_spr.delete(); q_cand.delete();
    n_cpr = 0; n_spr = 0; n_ad = 0; out_cnt = 0;
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 16; i++) e[i] = 8'((n * 7 + i) & 255);
      q_cpr.push_back(e);
    end
    for (int x = 0; x < 33; x++)
      for (int r = 0; r < 48; r++) begin
        for (int i = 0; i < 16; i++) e[i] = 8'((r * 7 + x + i) & 255);
        q_spr.push_back(e);
      end
    for (int x = 0; x < 33; x++)
      for (int y = 0; y < 33; y++) q_cand.push_back({6'(x), 6'(y)});
  endtask

  task automatic monitor();
    pix_t        ep;
    logic [11:0] ec;
    logic [5:0]  es;
    if (en_cpr) begin
      check("cpr_cycle", cyc, t_start + 2 + n_cpr);
      ep = 'x;
      if (q_cpr.size() != 0) ep = q_cpr.pop_front();
      check("cpr_data", pixel_cpr_out, ep);
      n_cpr++;
    end
    if (en_spr) begin
      check("spr_ready", ad_ready, 1'b1);
      ep = 'x;
      if (q_spr.size() != 0) ep = q_spr.pop_front();
      check("spr_data", pixel_spr_out, ep);
      n_spr++;
    end
    out_cnt = out_cnt + int'(srch_rd_en) - int'(en_spr);
    if (srch_rd_en) check("outstanding", out_cnt <= 2, 1'b1);
    if (ad_valid) begin
      ec = 'x;
      if (q_cand.size() != 0) ec = q_cand.pop_front();
      check("cand", {cand_x, cand_y}, ec);
      if (cand_x == 6'd5 && cand_y == 6'd10) hit = 1;
      n_ad++;
      t_last_ad = cyc;
    end
    if (done) begin
      check("done_gap", cyc, t_last_ad + 1);
      check("spr_total", n_spr, 1584);
      check("ad_total", n_ad, 1089);
      check("cpr_total", n_cpr, 16);
      check("q_left", q_spr.size() + q_cand.size(), 0);
      done_seen = 1;
    end
    if (en_cpr_s) begin
      check("s_cpr_data", pix_cpr_s, {4{8'h5A}});
      n_cpr_s++;
    end
    if (en_spr_s) begin
      check("s_spr_data", pix_spr_s, {4{8'h5A}});
      n_spr_s++;
    end
    if (ad_valid_s) begin
      es = 'x;
      if (q_s.size() != 0) es = q_s.pop_front();
      check("s_cand", {cx_s, cy_s}, es);
      n_ad_s++;
    end
    if (done_s) begin
      check("s_cpr_total", n_cpr_s, 4);
      check("s_spr_total", n_spr_s, 40);
      check("s_ad_total", n_ad_s, 25);
      check("s_q_left", q_s.size(), 0);
      done_s_seen = 1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    check({tag, "_ctl"}, {busy, done, cur_rd_en, cur_row, srch_rd_en, srch_row, srch_col,
                          en_cpr, en_spr, sel, ad_valid, cand_x, cand_y}, '0);
    check({tag, "_pix"}, {pixel_cpr_out, pixel_spr_out}, '0);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_start();
    start = 1; t_start = cyc;
    cycle();
    start = 0;
  endtask

  // mode 0: ready high, 1: random ready, 2: 100-cycle stall, 3: start while busy, 4: stop at (5,10)
  task automatic run(input int mode);
    int budget = 20000, iter = 0, stall_cnt = 0;
    done_seen = 0; hit = 0;
    while (!done_seen && !(mode == 4 && hit) && budget > 0) begin
      case (mode)
        1: ad_ready = 1'($urandom_range(0, 1));
        2: begin
          if (n_spr >= 600 && stall_cnt < 100) begin
            ad_ready = 0; stall_cnt++;
          end else if (stall_cnt == 100) begin
            check("stall_fill", out_cnt, 2);
            stall_cnt++; ad_ready = 1;
          end
        end
        3: start = (iter == 3) || (iter == 800);
        default: ad_ready = 1;
      endcase
      cycle();
      iter++; budget--;
    end
    start = 0; ad_ready = 1;
    if (mode == 4) check("hit_5_10", hit, 1'b1);
    else           check("done_seen", done_seen, 1'b1);
  endtask

  initial begin
    rst = 1; start = 0; start_s = 0; ad_ready = 1;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) q_s.push_back({3'(x), 3'(y)});
    load_expect();
    repeat (3) cycle();
    rst = 0;
    check_zero("reset");
    check("s_reset", {busy_s, done_s, en_cpr_s, en_spr_s, ad_valid_s, pix_cpr_s, pix_spr_s}, '0);

    // Nominal search on both configurations
    start_s = 1;
    do_start();
    start_s = 0;
    run(0);
    check("s_done_seen", done_s_seen, 1'b1);
    repeat (3) cycle();
    check("idle_busy", busy, 1'b0);

    // Random backpressure
    load_expect();
    do_start();
    run(1);

    // Long stall mid-scan
    load_expect();
    do_start();
    run(2);

    // start pulses while busy are ignored
    load_expect();
    do_start();
    run(3);
    repeat (5) cycle();
    check("no_restart_busy", busy, 1'b0);
    check("no_restart_cpr", n_cpr, 16);

    // Reset at candidate (5,10), then a clean search
    load_expect();
    do_start();
    run(4);
    rst = 1;
    cycle();
    rst = 0;
    check_zero("abort");
    load_expect();
    do_start();
    run(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
